// File: rtl/amp_seq_ctrl.sv
// rtl/amp_seq_ctrl.sv - class-D amp power/mute sequencer; optional feature macro AMP_SEQ_FAULT_RETRY_EN
module amp_seq_ctrl #(
  parameter int T_EN     = 1000,
  parameter int T_MUTE   = 500,
  parameter int LOCK_CYC = 64,
  parameter int CFG_TO   = 65535,
  parameter int T_RETRY  = 100000,
  parameter int CNT_W    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_req,
  input  logic       i2s_lock,
  input  logic       amp_fault,
  input  logic       fault_clr,
  output logic       cfg_req,
  input  logic       cfg_ack,
  input  logic       cfg_err,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic       fault_sticky,
  output logic [2:0] state_mon
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWRUP     = 3'd1,
    S_CONFIG    = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_PLAY      = 3'd4,
    S_MUTING    = 3'd5,
    S_PWRDN     = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  // Timer reload values: a state lasting N cycles is entered with N-1 and exits on 0.
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_MUTE  = CNT_W'(T_MUTE - 1);
  localparam logic [CNT_W-1:0] LD_CFG   = CNT_W'(CFG_TO - 1);
  localparam logic [CNT_W-1:0] LD_RETRY = CNT_W'(T_RETRY - 1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CYC);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             sticky_nxt;
  logic             nenable_nxt, nmute_nxt, cfg_req_nxt;
  logic             timer_done;
  logic             start_blocked;

  assign timer_done = (timer == '0);
  assign state_mon  = state;

`ifdef AMP_SEQ_FAULT_RETRY_EN
  // Timed retry lets the sequencer recover on its own; sticky is status only.
  assign start_blocked = 1'b0;
`else
  // Without retry, an uncleared fault must keep the amp powered down.
  assign start_blocked = fault_sticky;
`endif

  // State, timer, lock counter, sticky fault and decoded outputs all register here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_OFF;
      timer        <= '0;
      lock_cnt     <= '0;
      fault_sticky <= 1'b0;
      amp_nenable  <= 1'b1;
      amp_nmute    <= 1'b0;
      cfg_req      <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      lock_cnt     <= lock_cnt_nxt;
      fault_sticky <= sticky_nxt;
      amp_nenable  <= nenable_nxt;
      amp_nmute    <= nmute_nxt;
      cfg_req      <= cfg_req_nxt;
    end
  end

  // Next state, timer/lock counter updates, sticky fault and output decode.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    lock_cnt_nxt = lock_cnt;
    sticky_nxt   = fault_sticky;

    case (state)
      S_OFF:       if (play_req && !start_blocked) state_nxt = S_PWRUP;
      S_PWRUP:     if (timer_done) state_nxt = S_CONFIG;
      S_CONFIG: begin
        // cfg_req is never withdrawn early; play_req only picks the exit after ack.
        if (cfg_ack) begin
          if (cfg_err)       state_nxt = S_FAULT;
          else if (play_req) state_nxt = S_WAIT_LOCK;
          else               state_nxt = S_PWRDN;
        end else if (timer_done) begin
          state_nxt = S_FAULT;
        end
      end
      S_WAIT_LOCK: begin
        if (!play_req)                  state_nxt = S_PWRDN;
        else if (lock_cnt == LOCK_TGT)  state_nxt = S_PLAY;
      end
      S_PLAY:      if (!play_req || !i2s_lock) state_nxt = S_MUTING;
      S_MUTING:    if (timer_done) state_nxt = play_req ? S_WAIT_LOCK : S_PWRDN;
      S_PWRDN:     if (timer_done) state_nxt = S_OFF;
      S_FAULT: begin
        if (fault_clr && !amp_fault) state_nxt = S_OFF;
`ifdef AMP_SEQ_FAULT_RETRY_EN
        else if (!amp_fault && timer_done) state_nxt = S_OFF;
`endif
      end
      default:     state_nxt = S_OFF;
    endcase

    // A live amp fault overrides every other transition once the amp may be powered.
    if (amp_fault && state != S_OFF && state != S_FAULT) state_nxt = S_FAULT;

    // Set wins over clear; a clear during an active fault in FAULT is ignored.
    if (state_nxt == S_FAULT && state != S_FAULT) sticky_nxt = 1'b1;
    else if (fault_clr && !(state == S_FAULT && amp_fault)) sticky_nxt = 1'b0;

    if (state_nxt != state) begin
      lock_cnt_nxt = '0;
      case (state_nxt)
        S_PWRUP, S_PWRDN: timer_nxt = LD_EN;
        S_CONFIG:         timer_nxt = LD_CFG;
        S_MUTING:         timer_nxt = LD_MUTE;
        S_FAULT:          timer_nxt = LD_RETRY;
        default:          timer_nxt = '0;
      endcase
    end else begin
      if (state == S_FAULT && amp_fault) timer_nxt = LD_RETRY;
      else if (!timer_done)              timer_nxt = timer - CNT_W'(1);
      if (state == S_WAIT_LOCK) begin
        if (!i2s_lock)                  lock_cnt_nxt = '0;
        else if (lock_cnt != LOCK_TGT)  lock_cnt_nxt = lock_cnt + CNT_W'(1);
      end
    end

    nenable_nxt = !(state_nxt inside {S_PWRUP, S_CONFIG, S_WAIT_LOCK, S_PLAY, S_MUTING});
    nmute_nxt   = (state_nxt == S_PLAY);
    cfg_req_nxt = (state_nxt == S_CONFIG);
  end

endmodule
